// File: rtl/qea_core.sv
// qea_core: state-vector quantum emulator datapath.
// Applies a program of (controlled) 2x2 complex gates to a RAM-held state.
module qea_core #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int ALU_DATA_WIDTH          = DATA_WIDTH,
  parameter int STATE_DATA_WIDTH        = 2*DATA_WIDTH,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_DATA_WIDTH         = 2*DATA_WIDTH,
  parameter int GATE_ADDR_WIDTH         = 6,
  parameter int GATE_CONTEXT_DATA_WIDTH = 2*DATA_WIDTH,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_start,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic                                 i_ctx_en,
  input  logic                                 i_ctx_wea,
  input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ctx_addr,
  input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
  input  logic                                 i_state_ena,
  input  logic                                 i_state_wea,
  input  logic [STATE_ADDR_WIDTH-1:0]          i_state_addra,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dina,
  output logic                                 o_complete,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dout
);

  localparam int IDX_W  = STATE_ADDR_WIDTH + PE_NUM_WIDTH;
  localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;
  localparam int LW     = STATE_DATA_WIDTH;
  localparam int PROD_W = 2 * ALU_DATA_WIDTH;
  localparam int CW     = GATE_CONTEXT_DATA_WIDTH;
  localparam int AW     = GATE_CONTEXT_ADDR_WIDTH;

  typedef enum logic [3:0] {
    S_IDLE, S_LEN_W, S_LEN, S_HDR_W, S_HDR, S_COEF_W, S_COEF, S_SETUP,
    S_PAIR, S_RD0, S_RD1, S_RD2, S_WRI, S_WRJ, S_NEXT, S_DONE
  } state_t;

  function automatic logic [LW-1:0] get_lane(
    input logic [WORD_W-1:0] w, input logic [PE_NUM_WIDTH-1:0] l);
    return w[(PE_NUM-1-int'(l))*LW +: LW];
  endfunction

  function automatic logic [WORD_W-1:0] set_lane(
    input logic [WORD_W-1:0] w, input logic [PE_NUM_WIDTH-1:0] l,
    input logic [LW-1:0] a);
    logic [WORD_W-1:0] r;
    r = w;
    r[(PE_NUM-1-int'(l))*LW +: LW] = a;
    return r;
  endfunction

  // Full-width products summed, then truncated back to Q2.30.
  function automatic logic [LW-1:0] cmul(
    input logic [GATE_DATA_WIDTH-1:0] u, input logic [LW-1:0] a);
    logic signed [PROD_W-1:0] ur, ui, ar, ai, re, im;
    ur = PROD_W'(signed'(u[GATE_DATA_WIDTH-1 -: ALU_DATA_WIDTH]));
    ui = PROD_W'(signed'(u[ALU_DATA_WIDTH-1:0]));
    ar = PROD_W'(signed'(a[LW-1 -: ALU_DATA_WIDTH]));
    ai = PROD_W'(signed'(a[ALU_DATA_WIDTH-1:0]));
    re = ur*ar - ui*ai;
    im = ur*ai + ui*ar;
    return {ALU_DATA_WIDTH'(re >>> NUM_FRAC_BIT),
            ALU_DATA_WIDTH'(im >>> NUM_FRAC_BIT)};
  endfunction

  function automatic logic [LW-1:0] cadd(
    input logic [LW-1:0] x, input logic [LW-1:0] y);
    return {x[LW-1 -: DATA_WIDTH] + y[LW-1 -: DATA_WIDTH],
            x[DATA_WIDTH-1:0] + y[DATA_WIDTH-1:0]};
  endfunction

  logic [WORD_W-1:0] state_mem [2**STATE_ADDR_WIDTH];
  logic [CW-1:0]     ctx_mem   [2**AW];

  state_t                        state;
  logic [MAX_QBIT_WIDTH-1:0]     qn, tq, cq;
  logic [3:0]                    op;
  logic [15:0]                   gcnt, gate;
  logic [AW-1:0]                 ctx_ptr;
  logic [GATE_ADDR_WIDTH-1:0]    coef_i;
  logic [GATE_DATA_WIDTH-1:0]    u00, u01, u10, u11;
  logic [IDX_W-1:0]              pair;
  logic [STATE_ADDR_WIDTH-1:0]   raddr;
  logic [WORD_W-1:0]             wi, wj, eng_q;
  logic [CW-1:0]                 ctx_q;

  logic [IDX_W-1:0]              mask, idx_i, idx_j, last_pair;
  logic [STATE_ADDR_WIDTH-1:0]   addr_i, addr_j, eng_waddr;
  logic [PE_NUM_WIDTH-1:0]       lane_i, lane_j;
  logic                          same, ctrl_ok, host_ok, eng_we;
  logic [LW-1:0]                 ai, aj, ni, nj;
  logic [WORD_W-1:0]             eng_wdata;

  // Pair number p maps to index i by inserting a 0 at bit t.
  assign mask      = (IDX_W'(1) << tq) - IDX_W'(1);
  assign idx_i     = ((pair & ~mask) << 1) | (pair & mask);
  assign idx_j     = idx_i | (IDX_W'(1) << tq);
  assign addr_i    = idx_i[IDX_W-1:PE_NUM_WIDTH];
  assign addr_j    = idx_j[IDX_W-1:PE_NUM_WIDTH];
  assign lane_i    = idx_i[PE_NUM_WIDTH-1:0];
  assign lane_j    = idx_j[PE_NUM_WIDTH-1:0];
  assign same      = (addr_i == addr_j);
  assign last_pair = (IDX_W'(1) << (qn - MAX_QBIT_WIDTH'(1))) - IDX_W'(1);
  assign ctrl_ok   = (op != 4'd2) || (|((idx_i >> cq) & IDX_W'(1)));
  assign host_ok   = (state == S_IDLE) || (state == S_DONE);

  assign ai = get_lane(wi, lane_i);
  assign aj = get_lane(wj, lane_j);
  assign ni = cadd(cmul(u00, ai), cmul(u01, aj));
  assign nj = cadd(cmul(u10, ai), cmul(u11, aj));

  always_comb begin
    eng_we    = 1'b0;
    eng_waddr = addr_j;
    eng_wdata = set_lane(wj, lane_j, nj);
    if (state == S_WRI) begin
      eng_we    = 1'b1;
      eng_waddr = addr_i;
      eng_wdata = same ? set_lane(set_lane(wi, lane_i, ni), lane_j, nj)
                       : set_lane(wi, lane_i, ni);
    end else if (state == S_WRJ && !same) begin
      eng_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (host_ok && i_state_ena && i_state_wea)
      state_mem[i_state_addra] <= i_state_dina;
    else if (eng_we)
      state_mem[eng_waddr] <= eng_wdata;
    eng_q <= state_mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (host_ok && i_ctx_en && i_ctx_wea)
      ctx_mem[i_ctx_addr] <= i_ctx_data;
    ctx_q <= ctx_mem[ctx_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_state_dout <= '0;
    else if (host_ok && i_state_ena)
      o_state_dout <= state_mem[i_state_addra];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      o_complete <= 1'b0;
      qn         <= '0;
      tq         <= '0;
      cq         <= '0;
      op         <= '0;
      gcnt       <= '0;
      gate       <= '0;
      ctx_ptr    <= '0;
      coef_i     <= '0;
      u00        <= '0;
      u01        <= '0;
      u10        <= '0;
      u11        <= '0;
      pair       <= '0;
      raddr      <= '0;
      wi         <= '0;
      wj         <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            o_complete <= 1'b0;
            qn         <= i_qbit_num;
            ctx_ptr    <= '0;
            state      <= S_LEN_W;
          end
        end
        S_LEN_W: state <= S_LEN;
        S_LEN: begin
          gcnt <= ctx_q[15:0];
          gate <= '0;
          if (ctx_q[15:0] == 16'd0) begin
            o_complete <= 1'b1;
            state      <= S_DONE;
          end else begin
            ctx_ptr <= AW'(1);
            state   <= S_HDR_W;
          end
        end
        S_HDR_W: state <= S_HDR;
        S_HDR: begin
          op      <= ctx_q[CW-1 -: 4];
          tq      <= ctx_q[48 +: MAX_QBIT_WIDTH];
          cq      <= ctx_q[40 +: MAX_QBIT_WIDTH];
          ctx_ptr <= ctx_ptr + AW'(1);
          coef_i  <= '0;
          state   <= S_COEF_W;
        end
        S_COEF_W: state <= S_COEF;
        S_COEF: begin
          unique case (coef_i)
            GATE_ADDR_WIDTH'(0): u00 <= ctx_q;
            GATE_ADDR_WIDTH'(1): u01 <= ctx_q;
            GATE_ADDR_WIDTH'(2): u10 <= ctx_q;
            default:             u11 <= ctx_q;
          endcase
          ctx_ptr <= ctx_ptr + AW'(1);
          if (coef_i == GATE_ADDR_WIDTH'(3)) begin
            state <= S_SETUP;
          end else begin
            coef_i <= coef_i + GATE_ADDR_WIDTH'(1);
            state  <= S_COEF_W;
          end
        end
        S_SETUP: begin
          pair <= '0;
          if ((op != 4'd1 && op != 4'd2) || tq >= qn || cq >= qn)
            state <= S_NEXT;
          else
            state <= S_PAIR;
        end
        S_PAIR: begin
          if (ctrl_ok) begin
            raddr <= addr_i;
            state <= S_RD0;
          end else if (pair == last_pair) begin
            state <= S_NEXT;
          end else begin
            pair <= pair + IDX_W'(1);
          end
        end
        S_RD0: begin
          raddr <= addr_j;
          state <= S_RD1;
        end
        S_RD1: begin
          wi    <= eng_q;
          state <= S_RD2;
        end
        S_RD2: begin
          wj    <= eng_q;
          state <= S_WRI;
        end
        S_WRI: state <= S_WRJ;
        S_WRJ: begin
          if (pair == last_pair) begin
            state <= S_NEXT;
          end else begin
            pair  <= pair + IDX_W'(1);
            state <= S_PAIR;
          end
        end
        S_NEXT: begin
          if (gate == gcnt - 16'd1) begin
            o_complete <= 1'b1;
            state      <= S_DONE;
          end else begin
            gate  <= gate + 16'd1;
            state <= S_HDR_W;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qea_core.sv
// tb_qea_core: directed gate programs checked against a behavioural
// state-vector model through a readback scoreboard.
module tb_qea_core;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [5:0]   qbit_num;
  logic         ctx_en, ctx_wea;
  logic [15:0]  ctx_addr;
  logic [63:0]  ctx_data;
  logic         st_ena, st_wea;
  logic [15:0]  st_addr;
  logic [255:0] st_din;
  logic         complete;
  logic [255:0] st_dout;

  always #5 clk = ~clk;

  qea_core dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_qbit_num   (qbit_num),
    .i_ctx_en     (ctx_en),
    .i_ctx_wea    (ctx_wea),
    .i_ctx_addr   (ctx_addr),
    .i_ctx_data   (ctx_data),
    .i_state_ena  (st_ena),
    .i_state_wea  (st_wea),
    .i_state_addra(st_addr),
    .i_state_dina (st_din),
    .o_complete   (complete),
    .o_state_dout (st_dout)
  );

  localparam logic [63:0] ONE = 64'h40000000_00000000;
  localparam logic [63:0] HP  = 64'h2D413CCC_00000000;
  localparam logic [63:0] HN  = 64'hD2BEC334_00000000;

  logic [63:0]  amp [32];
  logic [255:0] sb [$];
  int checks = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] cm(input logic [63:0] a,
                                     input logic [63:0] b);
    longint ar, ai, br, bi, re, im;
    ar = longint'(signed'(a[63:32]));
    ai = longint'(signed'(a[31:0]));
    br = longint'(signed'(b[63:32]));
    bi = longint'(signed'(b[31:0]));
    re = (ar*br - ai*bi) >>> 30;
    im = (ar*bi + ai*br) >>> 30;
    return {re[31:0], im[31:0]};
  endfunction

  function automatic logic [63:0] ca(input logic [63:0] a,
                                     input logic [63:0] b);
    return {a[63:32] + b[63:32], a[31:0] + b[31:0]};
  endfunction

  function automatic logic [255:0] word_of(input int w);
    logic [255:0] r;
    for (int l = 0; l < 4; l++) r[(3-l)*64 +: 64] = amp[w*4+l];
    return r;
  endfunction

  task automatic ctx_wr(input int a, input logic [63:0] d);
    @(negedge clk);
    ctx_en = 1'b1; ctx_wea = 1'b1; ctx_addr = 16'(a); ctx_data = d;
    @(negedge clk);
    ctx_en = 1'b0; ctx_wea = 1'b0;
  endtask

  task automatic st_wr(input int w, input logic [255:0] d);
    @(negedge clk);
    st_ena = 1'b1; st_wea = 1'b1; st_addr = 16'(w); st_din = d;
    @(negedge clk);
    st_ena = 1'b0; st_wea = 1'b0;
  endtask

  task automatic load_state(input int n);
    for (int w = 0; w < (1 << (n-2)); w++) st_wr(w, word_of(w));
  endtask

  task automatic basis(input int n, input int k);
    for (int i = 0; i < 32; i++) amp[i] = '0;
    amp[k] = ONE;
    load_state(n);
  endtask

  // Writes gate g into the context RAM and applies it to the model.
  task automatic gate(input int g, input int n, input logic [3:0] op,
                      input int t, input int c,
                      input logic [63:0] a00, input logic [63:0] a01,
                      input logic [63:0] a10, input logic [63:0] a11);
    logic [63:0] h, x, y;
    h = '0;
    h[63:60] = op;
    h[48 +: 6] = 6'(t);
    h[40 +: 6] = 6'(c);
    ctx_wr(1+5*g, h);
    ctx_wr(2+5*g, a00);
    ctx_wr(3+5*g, a01);
    ctx_wr(4+5*g, a10);
    ctx_wr(5+5*g, a11);
    if ((op == 4'd1 || op == 4'd2) && t < n && c < n) begin
      for (int i = 0; i < (1 << n); i++) begin
        if (((i >> t) & 1) == 0 && (op != 4'd2 || ((i >> c) & 1) == 1)) begin
          x = amp[i];
          y = amp[i | (1 << t)];
          amp[i] = ca(cm(a00, x), cm(a01, y));
          amp[i | (1 << t)] = ca(cm(a10, x), cm(a11, y));
        end
      end
    end
  endtask

  task automatic start_pulse(input int n);
    qbit_num = 6'(n);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk); #1;
      if (complete) ok = 1'b1;
    end
    check(tag, 256'(ok), 256'(1));
  endtask

  task automatic run(input int n, input int g, input string tag);
    ctx_wr(0, 64'(g));
    start_pulse(n);
    wait_done(8*(1 << n)*(g+1) + 64, tag);
  endtask

  task automatic readback(input int n, input string tag);
    for (int w = 0; w < (1 << (n-2)); w++) begin
      sb.push_back(word_of(w));
      @(negedge clk);
      st_ena = 1'b1; st_wea = 1'b0; st_addr = 16'(w);
      @(posedge clk); #1;
      check($sformatf("%s w%0d", tag, w), st_dout, sb.pop_front());
    end
    @(negedge clk); st_ena = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; qbit_num = '0;
    ctx_en = 1'b0; ctx_wea = 1'b0; ctx_addr = '0; ctx_data = '0;
    st_ena = 1'b0; st_wea = 1'b0; st_addr = '0; st_din = '0;
    #12;
    check("rst complete", 256'(complete), 256'(0));
    check("rst dout", st_dout, 256'(0));
    @(negedge clk); rst = 1'b0;

    // T1 identity
    basis(3, 0);
    gate(0, 3, 4'd1, 0, 0, ONE, 64'd0, 64'd0, ONE);
    run(3, 1, "t1 done");
    readback(3, "t1");
    sb.push_back(word_of(1));
    @(posedge clk); #1;
    check("t1 hold", st_dout, sb.pop_front());

    // T2 Hadamard
    basis(3, 0);
    gate(0, 3, 4'd1, 0, 0, HP, HP, HP, HN);
    run(3, 1, "t2 done");
    readback(3, "t2");

    // T3 cross-word X
    basis(3, 0);
    gate(0, 3, 4'd1, 2, 0, 64'd0, ONE, ONE, 64'd0);
    run(3, 1, "t3 done");
    readback(3, "t3");

    // T4 X then CNOT
    basis(3, 0);
    gate(0, 3, 4'd1, 0, 0, 64'd0, ONE, ONE, 64'd0);
    gate(1, 3, 4'd2, 1, 0, 64'd0, ONE, ONE, 64'd0);
    run(3, 2, "t4 done");
    readback(3, "t4");

    // Mixed program: rotation, phase CNOT, NOPs, skipped gate, H
    for (int k = 0; k < 32; k++)
      amp[k] = {32'(k*32'h01000000 - 32'h05000000), 32'(k*32'h00300000)};
    load_state(4);
    gate(0, 4, 4'd1, 3, 0, 64'h376CF5D0_08000000, 64'hE0000000_00000000,
         64'h20000000_00000000, 64'h376CF5D0_F8000000);
    gate(1, 4, 4'd2, 0, 2, 64'd0, 64'h00000000_40000000,
         64'h00000000_C0000000, 64'd0);
    gate(2, 4, 4'd0, 1, 0, 64'd0, ONE, ONE, 64'd0);
    gate(3, 4, 4'd7, 1, 0, 64'd0, ONE, ONE, 64'd0);
    gate(4, 4, 4'd1, 5, 0, 64'd0, ONE, ONE, 64'd0);
    gate(5, 4, 4'd1, 1, 0, HP, HP, HP, HN);
    run(4, 6, "mix done");
    readback(4, "mix");

    // T5 start and host write while busy are ignored; restart with G=0
    basis(3, 0);
    gate(0, 3, 4'd1, 0, 0, 64'd0, ONE, ONE, 64'd0);
    ctx_wr(0, 64'd1);
    start_pulse(3);
    repeat (22) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    st_wr(0, '1);
    wait_done(8*8*2 + 64, "t5 done");
    readback(3, "t5");
    ctx_wr(0, 64'd0);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("t5 drop", 256'(complete), 256'(0));
    @(negedge clk); start = 1'b0;
    wait_done(64, "t5 g0 done");

    // T6 reset mid-apply
    basis(5, 0);
    readback(2, "t6 pre");
    gate(0, 5, 4'd1, 4, 0, 64'd0, ONE, ONE, 64'd0);
    ctx_wr(0, 64'd1);
    start_pulse(5);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6 rst complete", 256'(complete), 256'(0));
    check("t6 rst dout", st_dout, 256'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    basis(3, 0);
    gate(0, 3, 4'd1, 0, 0, HP, HP, HP, HN);
    run(3, 1, "t6 done");
    readback(3, "t6");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
